// File: rtl/boat_renderer.sv
// Pixel-streaming renderer for the BoatB game: snapshots the game state on Start, clears the
// 160x120 frame, then plots crew, boat, corpse and lives sprites one pixel per clock.
module boat_renderer #(
  parameter logic [7:0] CREW_X0   = 8'd32,
  parameter logic [7:0] COL_PITCH = 8'd24,
  parameter logic [6:0] CREW_Y0   = 7'd16,
  parameter logic [6:0] ROW_PITCH = 7'd14,
  parameter logic [6:0] BOAT_Y    = 7'd104,
  parameter logic [6:0] CORPSE_Y  = 7'd112,
  parameter logic [2:0] BG_COL    = 3'b000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [2:0] Position,
  input  logic [5:0] FlCrew,
  input  logic [5:0] MlCrew,
  input  logic [5:0] MrCrew,
  input  logic [5:0] FrCrew,
  input  logic [2:0] Corpses,
  input  logic [1:0] Lives,
  output logic [7:0] VGAx,
  output logic [6:0] VGAy,
  output logic [2:0] VGAcol,
  output logic       Plot,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_OBJ, S_FIN} state_e;

  localparam logic [4:0] LAST_OBJ = 5'd28;
  localparam logic [7:0] BOAT_X0  = CREW_X0 - COL_PITCH - 8'd6;
  localparam logic [7:0] LIFE_X0  = 8'd140;
  localparam logic [6:0] LIFE_Y   = 7'd4;

  state_e          state_q, state_d;
  logic [3:0][5:0] crew_q, crew_d;
  logic [2:0]      pos_q, pos_d;
  logic [2:0]      corpse_q, corpse_d;
  logic [1:0]      lives_q, lives_d;
  logic [7:0]      cx_q, cx_d;
  logic [6:0]      cy_q, cy_d;
  logic [4:0]      obj_q, obj_d;
  logic [3:0]      px_q, px_d;
  logic [1:0]      py_q, py_d;
  logic [7:0]      vx_q, vx_d;
  logic [6:0]      vy_q, vy_d;
  logic [2:0]      col_q, col_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            obj_en;
  logic [7:0]      obj_x;
  logic [6:0]      obj_y;
  logic [2:0]      obj_col;
  logic [3:0]      obj_wm1;
  logic [1:0]      crew_c;
  logic [2:0]      crew_r;
  logic [1:0]      life_i;
  logic            obj_last;

  // Geometry and enable of the object currently selected by obj_q.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    crew_c  = 2'(obj_q / 5'd6);
    crew_r  = 3'(obj_q % 5'd6);
    life_i  = 2'(obj_q - 5'd26);
    obj_en  = 1'b0;
    obj_x   = '0;
    obj_y   = '0;
    obj_col = '0;
    obj_wm1 = 4'd3;
    if (obj_q < 5'd24) begin
      obj_en  = crew_q[crew_c][crew_r];
      obj_x   = CREW_X0 + 8'(crew_c) * COL_PITCH;
      obj_y   = CREW_Y0 + 7'(crew_r) * ROW_PITCH;
      obj_col = 3'b111;
    end else if (obj_q == 5'd24) begin
      obj_en  = (pos_q <= 3'd5);
      obj_x   = BOAT_X0 + 8'(pos_q) * COL_PITCH;
      obj_y   = BOAT_Y;
      obj_col = 3'b100;
      obj_wm1 = 4'd15;
    end else if (obj_q == 5'd25) begin
      obj_en  = corpse_q[2];
      obj_x   = CREW_X0 + 8'(corpse_q[1:0]) * COL_PITCH;
      obj_y   = CORPSE_Y;
      obj_col = 3'b110;
    end else begin
      obj_en  = (life_i < lives_q);
      obj_x   = LIFE_X0 + 8'(life_i) * 8'd6;
      obj_y   = LIFE_Y;
      obj_col = 3'b100;
    end
  end

  always_comb begin
    state_d  = state_q;
    crew_d   = crew_q;
    pos_d    = pos_q;
    corpse_d = corpse_q;
    lives_d  = lives_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    obj_d    = obj_q;
    px_d     = px_q;
    py_d     = py_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    col_d    = col_q;
    plot_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    obj_last = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          crew_d   = {FrCrew, MrCrew, MlCrew, FlCrew};
          pos_d    = Position;
          corpse_d = Corpses;
          lives_d  = Lives;
          cx_d     = '0;
          cy_d     = '0;
          busy_d   = 1'b1;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        plot_d = 1'b1;
        vx_d   = cx_q;
        vy_d   = cy_q;
        col_d  = BG_COL;
        if (cx_q == 8'd159) begin
          cx_d = '0;
          if (cy_q == 7'd119) begin
            state_d = S_OBJ;
            obj_d   = '0;
            px_d    = '0;
            py_d    = '0;
          end else begin
            cy_d = cy_q + 7'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      S_OBJ: begin
        if (obj_en) begin
          plot_d = 1'b1;
          vx_d   = obj_x + 8'(px_q);
          vy_d   = obj_y + 7'(py_q);
          col_d  = obj_col;
          if (px_q == obj_wm1) begin
            px_d = '0;
            if (py_q == 2'd3) begin
              py_d     = '0;
              obj_last = 1'b1;
            end else begin
              py_d = py_q + 2'd1;
            end
          end else begin
            px_d = px_q + 4'd1;
          end
        end else begin
          // A disabled object still costs one idle cycle, keeping pass length deterministic.
          obj_last = 1'b1;
        end
        if (obj_last) begin
          if (obj_q == LAST_OBJ) state_d = S_FIN;
          else                   obj_d   = obj_q + 5'd1;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= S_IDLE;
      crew_q   <= '0;
      pos_q    <= '0;
      corpse_q <= '0;
      lives_q  <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      obj_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      col_q    <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      crew_q   <= crew_d;
      pos_q    <= pos_d;
      corpse_q <= corpse_d;
      lives_q  <= lives_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      obj_q    <= obj_d;
      px_q     <= px_d;
      py_q     <= py_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      col_q    <= col_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign VGAx   = vx_q;
  assign VGAy   = vy_q;
  assign VGAcol = col_q;
  assign Plot   = plot_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_boat_renderer.sv
// Self-checking bench for boat_renderer: a sprite-level reference model builds the expected
// per-cycle pixel stream for each pass, which is compared cycle by cycle against the DUT.
module tb_boat_renderer;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       Start = 1'b0;
  logic [2:0] Position = '0;
  logic [5:0] FlCrew = '0, MlCrew = '0, MrCrew = '0, FrCrew = '0;
  logic [2:0] Corpses = '0;
  logic [1:0] Lives = '0;
  logic [7:0] VGAx;
  logic [6:0] VGAy;
  logic [2:0] VGAcol;
  logic       Plot, Busy, Done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]      pos;
    logic [3:0][5:0] crew;
    logic [2:0]      corpses;
    logic [1:0]      lives;
  } snap_t;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] col;
  } pix_t;

  pix_t exp_q[$];

  boat_renderer dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Position(Position),
    .FlCrew(FlCrew), .MlCrew(MlCrew), .MrCrew(MrCrew), .FrCrew(FrCrew),
    .Corpses(Corpses), .Lives(Lives), .VGAx(VGAx), .VGAy(VGAy), .VGAcol(VGAcol),
    .Plot(Plot), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input snap_t s);
    Position = s.pos;
    FlCrew   = s.crew[0];
    MlCrew   = s.crew[1];
    MrCrew   = s.crew[2];
    FrCrew   = s.crew[3];
    Corpses  = s.corpses;
    Lives    = s.lives;
  endtask

  // Enabled sprite: w*h pixels raster order; disabled: one non-plot cycle holding the last pixel.
  task automatic add_sprite(input bit en, input int x, input int y, input int w, input int h,
                            input int col);
    pix_t p;
    if (en) begin
      for (int j = 0; j < h; j++)
        for (int i = 0; i < w; i++) begin
          p.plot = 1'b1;
          p.x    = 8'(x + i);
          p.y    = 7'(y + j);
          p.col  = 3'(col);
          exp_q.push_back(p);
        end
    end else begin
      p      = exp_q[$];
      p.plot = 1'b0;
      exp_q.push_back(p);
    end
  endtask

  task automatic build_model(input snap_t s);
    pix_t p;
    exp_q.delete();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        p.plot = 1'b1;
        p.x    = 8'(x);
        p.y    = 7'(y);
        p.col  = 3'b000;
        exp_q.push_back(p);
      end
    for (int idx = 0; idx < 24; idx++)
      add_sprite(s.crew[idx / 6][idx % 6], 32 + 24 * (idx / 6), 16 + 14 * (idx % 6), 4, 4, 7);
    add_sprite(int'(s.pos) <= 5, 2 + 24 * int'(s.pos), 104, 16, 4, 4);
    add_sprite(s.corpses[2], 32 + 24 * int'(s.corpses[1:0]), 112, 4, 4, 6);
    for (int i = 0; i < 3; i++)
      add_sprite(i < int'(s.lives), 140 + 6 * i, 4, 4, 4, 4);
  endtask

  // One pass: optional input toggle + Start pulse at stream cycle perturb_at, optional reset at reset_at.
  task automatic run_pass(input string name, input snap_t s, input int perturb_at, input int reset_at);
    pix_t got;
    build_model(s);
    @(negedge Clock);
    apply(s);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    check({name, "_busy_start"}, 32'(Busy), 32'd1);
    check({name, "_plot_start"}, 32'(Plot), 32'd0);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == perturb_at) begin
        apply(snap_t'(~s));
        Start = 1'b1;
      end else if (k == perturb_at + 1) begin
        Start = 1'b0;
      end
      if (k == reset_at) begin
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        check({name, "_rst_plot"}, 32'(Plot), 32'd0);
        check({name, "_rst_busy"}, 32'(Busy), 32'd0);
        check({name, "_rst_done"}, 32'(Done), 32'd0);
        repeat (3) begin
          @(negedge Clock);
          check({name, "_rst_nodone"}, 32'(Done), 32'd0);
          check({name, "_rst_idle"}, 32'(Busy), 32'd0);
        end
        return;
      end
      @(negedge Clock);
      got = {Plot, VGAx, VGAy, VGAcol};
      check($sformatf("%s_pix%0d", name, k), 32'(got), 32'(exp_q[k]));
    end
    @(negedge Clock);
    check({name, "_done"}, 32'(Done), 32'd1);
    check({name, "_busy_end"}, 32'(Busy), 32'd0);
    check({name, "_plot_end"}, 32'(Plot), 32'd0);
    @(negedge Clock);
    check({name, "_done_once"}, 32'(Done), 32'd0);
    check({name, "_idle"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    snap_t s;

    // Reset state.
    repeat (2) @(negedge Clock);
    check("rst_plot", 32'(Plot), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_x", 32'(VGAx), 32'd0);
    check("rst_y", 32'(VGAy), 32'd0);
    check("rst_col", 32'(VGAcol), 32'd0);
    Resetn = 1'b1;

    // Empty board, boat at position 1.
    s = '0;
    s.pos = 3'd1;
    run_pass("empty", s, -1, -1);

    // Edge crew cells, corpse in column 3, two lives used, no boat; inputs toggled mid-pass.
    s = '0;
    s.crew[0] = 6'b100000;
    s.crew[3] = 6'b000001;
    s.corpses = 3'b111;
    s.lives   = 2'd2;
    s.pos     = 3'd6;
    run_pass("sprites", s, 1000, -1);

    // Reset aborts a pass.
    run_pass("abort", s, -1, 500);

    // Random game state after the abort.
    s.pos     = 3'($urandom_range(0, 7));
    s.crew    = 24'($urandom);
    s.corpses = 3'($urandom);
    s.lives   = 2'($urandom);
    run_pass("random", s, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
